// File: rtl/aes_core_arbiter_pkg.sv
// Shared types and constants for the AES core arbiter: block/key sizes, FSM
// state encodings and an index-width helper.
package aes_core_arbiter_pkg;

    localparam int BLK_S = 128;
    localparam int KEY_S = 128;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    // Requester index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_core_arbiter_rr_pick.sv
// Rotating-priority encoder: picks the first asserted request at or above
// i_ptr, wrapping around to index 0.
module aes_core_arbiter_rr_pick
    import aes_core_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && i_req[j] && (IDX_W'(j) >= i_ptr)) begin
                o_any = 1'b1;
                o_idx = IDX_W'(j);
            end
        end
        // Second pass covers the wrapped-around indices below the pointer.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && i_req[j] && (IDX_W'(j) < i_ptr)) begin
                o_any = 1'b1;
                o_idx = IDX_W'(j);
            end
        end
        o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one AES core between NUM_REQ block requesters.
// Define AES_ARB_KEY_CACHE_EN to skip key re-strobes while the key is unchanged.
module aes_core_arbiter
    import aes_core_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int BLK_W   = BLK_S,
    parameter int KEY_W   = KEY_S
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_key_new,
    input  logic [NUM_REQ*KEY_W-1:0] req_key,
    input  logic [NUM_REQ*BLK_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [BLK_W-1:0]         resp_data,
    output logic                     busy,
    output logic                     aes_en,
    output logic                     aes_key_strobe,
    output logic [KEY_W-1:0]         aes_key,
    output logic [BLK_W-1:0]         aes_plaintext,
    input  logic [BLK_W-1:0]         aes_ciphertext,
    input  logic                     aes_done
);

    localparam int IDX_W = idx_w(NUM_REQ);

    arb_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_g, r_rr_ptr, w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_any, w_reload, r_reload;
    logic [KEY_W-1:0]   w_key, r_aes_key;
    logic [BLK_W-1:0]   w_data, r_aes_pt, r_resp_data;

    aes_core_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_key  = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_key  = req_key[i*KEY_W +: KEY_W];
                w_data = req_data[i*BLK_W +: BLK_W];
            end
        end
    end

`ifdef AES_ARB_KEY_CACHE_EN
    logic             r_key_loaded;
    logic [IDX_W-1:0] r_key_owner;

    assign w_reload = !r_key_loaded || (w_idx != r_key_owner) || req_key_new[w_idx];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_key_loaded <= 1'b0;
            r_key_owner  <= '0;
        end else if (r_state == ARB_ISSUE) begin
            r_key_loaded <= 1'b1;
            r_key_owner  <= r_g;
        end
    end
`else
    logic w_unused_key_new;

    assign w_reload         = 1'b1;
    assign w_unused_key_new = ^req_key_new;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        req_ready      = '0;
        resp_valid     = '0;
        aes_en         = 1'b0;
        aes_key_strobe = 1'b0;
        busy           = (r_state != ARB_IDLE);
        unique case (r_state)
            ARB_IDLE: begin
                req_ready = w_grant;
                if (w_any) w_state_nxt = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                aes_en         = 1'b1;
                aes_key_strobe = r_reload;
                w_state_nxt    = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (aes_done) w_state_nxt = ARB_RESP;
            end
            ARB_RESP: begin
                resp_valid = NUM_REQ'(1) << r_g;
                if (resp_ready[r_g]) w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ARB_IDLE;
            r_g         <= '0;
            r_rr_ptr    <= '0;
            r_reload    <= 1'b0;
            r_aes_key   <= '0;
            r_aes_pt    <= '0;
            r_resp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ARB_IDLE: if (w_any) begin
                    r_g       <= w_idx;
                    r_aes_key <= w_key;
                    r_aes_pt  <= w_data;
                    r_reload  <= w_reload;
                end
                ARB_WAIT: if (aes_done) r_resp_data <= aes_ciphertext;
                ARB_RESP: if (resp_ready[r_g]) begin
                    r_rr_ptr <= (r_g == IDX_W'(NUM_REQ - 1)) ? '0 : r_g + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign aes_key       = r_aes_key;
    assign aes_plaintext = r_aes_pt;
    assign resp_data     = r_resp_data;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with NUM_REQ = 2; the bench plays the AES core.
module tb_aes_core_arbiter;
    import aes_core_arbiter_pkg::*;

    localparam int N = 2;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1 = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] PA = 128'h0123456789abcdef0011223344556677;
    localparam logic [127:0] PB = 128'hdeadbeefcafef00d1234567890abcdef;
    localparam logic [127:0] PC = 128'h5555aaaa5555aaaa3333cccc3333cccc;
`ifdef AES_ARB_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [N-1:0]   req_valid, req_ready, req_key_new, resp_valid, resp_ready;
    logic [N*128-1:0] req_key, req_data;
    logic [127:0]   resp_data, aes_key, aes_plaintext, aes_ciphertext;
    logic           busy, aes_en, aes_key_strobe, aes_done;

    int n_err = 0;
    int n_chk = 0;

    aes_core_arbiter #(.NUM_REQ(N), .BLK_W(128), .KEY_W(128)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_key_new    (req_key_new),
        .req_key        (req_key),
        .req_data       (req_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .busy           (busy),
        .aes_en         (aes_en),
        .aes_key_strobe (aes_key_strobe),
        .aes_key        (aes_key),
        .aes_plaintext  (aes_plaintext),
        .aes_ciphertext (aes_ciphertext),
        .aes_done       (aes_done)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Core stand-in: the FIPS-197 vector, otherwise key XOR plaintext.
    function automatic logic [127:0] model_ct(input logic [127:0] k, input logic [127:0] p);
        return (k == K0 && p == P0) ? C0 : (k ^ p);
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req_ready"}, 128'(req_ready), '0);
        check_eq({tag, "_resp_valid"}, 128'(resp_valid), '0);
        check_eq({tag, "_resp_data"}, resp_data, '0);
        check_eq({tag, "_busy"}, 128'(busy), '0);
        check_eq({tag, "_aes_en"}, 128'(aes_en), '0);
        check_eq({tag, "_strobe"}, 128'(aes_key_strobe), '0);
        check_eq({tag, "_aes_key"}, aes_key, '0);
        check_eq({tag, "_aes_pt"}, aes_plaintext, '0);
    endtask

    // Request through accept until ISSUE is observed; returns at the ISSUE negedge.
    task automatic grant_issue(input int r, input logic [127:0] key, input logic [127:0] pt,
                               input logic knew, input logic exp_strb, input logic drop);
        int n;
        req_key[r*128 +: 128]  = key;
        req_data[r*128 +: 128] = pt;
        req_key_new[r]         = knew;
        req_valid[r]           = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 30) begin
            @(negedge aclk);
            #1;
            n++;
        end
        check_eq("grant", 128'(req_ready), 128'(1) << r);
        @(negedge aclk);
        if (drop) begin
            req_valid[r]   = 1'b0;
            req_key_new[r] = 1'b0;
        end
        check_eq("issue_en", 128'(aes_en), 128'(1));
        check_eq("issue_strobe", 128'(aes_key_strobe), 128'(exp_strb));
        check_eq("issue_key", aes_key, key);
        check_eq("issue_pt", aes_plaintext, pt);
    endtask

    task automatic do_block(input int r, input logic [127:0] key, input logic [127:0] pt,
                            input logic knew, input logic exp_strb, input int hold, input logic drop);
        logic [127:0] ct;
        ct = model_ct(key, pt);
        grant_issue(r, key, pt, knew, exp_strb, drop);
        @(negedge aclk);
        check_eq("wait_en_low", 128'(aes_en), '0);
        repeat (2) @(negedge aclk);
        check_eq("wait_key_hold", aes_key, key);
        check_eq("wait_pt_hold", aes_plaintext, pt);
        aes_ciphertext = ct;
        aes_done       = 1'b1;
        @(negedge aclk);
        aes_done       = 1'b0;
        aes_ciphertext = '0;
        check_eq("resp_valid", 128'(resp_valid), 128'(1) << r);
        check_eq("resp_data", resp_data, ct);
        for (int h = 0; h < hold; h++) begin
            @(negedge aclk);
            check_eq("bp_resp_valid", 128'(resp_valid), 128'(1) << r);
            check_eq("bp_resp_data", resp_data, ct);
            check_eq("bp_busy", 128'(busy), 128'(1));
            check_eq("bp_req_ready", 128'(req_ready), '0);
        end
        resp_ready[r] = 1'b1;
        @(negedge aclk);
        resp_ready[r] = 1'b0;
        check_eq("idle_busy", 128'(busy), '0);
        check_eq("idle_resp_valid", 128'(resp_valid), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        req_valid = '0; req_key_new = '0; req_key = '0; req_data = '0;
        resp_ready = '0; aes_ciphertext = '0; aes_done = 1'b0;
        repeat (3) @(negedge aclk);
        check_quiet("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        // FIPS-197 single block, first key always strobed
        do_block(0, K0, P0, 1'b0, 1'b1, 0, 1'b1);

        // Same requester, same key: cached unless the feature is off
        do_block(0, K0, P0, 1'b0, !CACHE, 0, 1'b1);
        do_block(0, K0, PA, 1'b0, !CACHE, 0, 1'b1);

        // Owner change with identical key, then forced reload
        do_block(1, K0, PA, 1'b0, 1'b1, 0, 1'b1);
        do_block(1, K0, PB, 1'b1, 1'b1, 0, 1'b1);
        do_block(1, K0, PB, 1'b0, !CACHE, 0, 1'b1);

        // Contention, rr_ptr back at 0: order 0,1,0,1
        req_key[0 +: 128] = K0; req_data[0 +: 128] = PA;
        req_key[128 +: 128] = K1; req_data[128 +: 128] = PB;
        req_valid = 2'b11;
        do_block(0, K0, PA, 1'b0, 1'b1, 0, 1'b0);
        do_block(1, K1, PB, 1'b0, 1'b1, 0, 1'b0);
        do_block(0, K0, PC, 1'b0, 1'b1, 0, 1'b0);
        do_block(1, K1, PA, 1'b0, 1'b1, 0, 1'b0);
        req_valid = '0;

        // Backpressure on requester 0 while requester 1 waits
        req_key[128 +: 128] = K1; req_data[128 +: 128] = PC;
        req_valid[1] = 1'b1;
        do_block(0, K0, PB, 1'b0, 1'b1, 10, 1'b1);
        check_eq("bp_next_grant", 128'(req_ready), 128'(2'b10));
        do_block(1, K1, PC, 1'b0, 1'b1, 0, 1'b1);

        // Reset while waiting for the core
        grant_issue(1, K1, PA, 1'b0, !CACHE, 1'b1);
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check_quiet("midreset");
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        aes_ciphertext = 128'h1234;
        aes_done = 1'b1;
        @(negedge aclk);
        aes_done = 1'b0;
        aes_ciphertext = '0;
        @(negedge aclk);
        check_eq("post_reset_resp_valid", 128'(resp_valid), '0);
        check_eq("post_reset_busy", 128'(busy), '0);
        do_block(1, K1, PA, 1'b0, 1'b1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one aes_top core between NUM_REQ block-level requesters using round-robin arbitration.
- Sequences each request through the core: key strobe, start pulse, wait for done, return ciphertext.
- Re-strobes the key only when it changes, so key expansion is skipped for consecutive blocks under the same key.
- Sits between per-channel AXI-stream front ends (block assemblers) and the single aes_top instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BLK_W, 128, block width; equals `BLK_S.
- KEY_W, 128, key width; equals `KEY_S.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request valid; held until accepted.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_key_new  in  NUM_REQ  requester forces a key reload for this block.
- req_key  in  NUM_REQ*KEY_W  flattened keys; requester i at [i*KEY_W +: KEY_W].
- req_data  in  NUM_REQ*BLK_W  flattened plaintexts; same slicing.
- resp_valid  out  NUM_REQ  one-hot ciphertext valid.
- resp_ready  in  NUM_REQ  per-requester response accept.
- resp_data  out  BLK_W  ciphertext, shared; meaningful only with a resp_valid bit set.
- busy  out  1  high in any state other than IDLE.
- aes_en  out  1  start pulse to the core.
- aes_key_strobe  out  1  key-load qualifier to the core.
- aes_key  out  KEY_W  registered key to the core.
- aes_plaintext  out  BLK_W  registered plaintext to the core.
- aes_ciphertext  in  BLK_W  core result.
- aes_done  in  1  core done pulse (en_o).

Behaviour:
- Clock and reset: one clock aclk; reset aresetn is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; rr_ptr 0; key_loaded 0; key_owner 0.
- Reset mid-operation (any state) aborts the transaction silently; no resp_valid is produced. The core is reset by the same aresetn.

State machine (IDLE, ISSUE, WAIT, RESP):
- IDLE:
  - g = first i with req_valid[i], searching from rr_ptr upward with wrap-around.
  - req_ready[g] is asserted combinationally (gated by state == IDLE) in that same cycle.
  - On the transfer: latch key, data and g; set reload = !key_loaded | (g != key_owner) | req_key_new[g]; go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE:
  - aes_en = 1 for exactly one cycle; aes_key_strobe = reload in the same cycle.
  - key_loaded <= 1; key_owner <= g; go to WAIT.
- WAIT:
  - Hold aes_key and aes_plaintext stable.
  - On aes_done: resp_data <= aes_ciphertext; go to RESP.
  - aes_done seen in any other state is ignored.
  - No timeout (see Optional Feature).
- RESP:
  - resp_valid[g] = 1 until resp_ready[g]. resp_data is held stable.
  - On the handshake: rr_ptr <= (g+1) mod NUM_REQ; go to IDLE.
- Timing and fairness:
  - Minimum overhead is 3 cycles plus core latency per block.
  - Back-to-back throughput is limited by the mandatory return to IDLE.
  - A requester dropping req_valid before acceptance is legal; it is simply not granted.
  - Simultaneous requests are served strictly round-robin, so no requester starves.
- req_ready and resp_valid are never multi-hot.
- Width rules: NUM_REQ slicing uses ceil(log2(NUM_REQ)) index bits (minimum 1); rr_ptr wraps at NUM_REQ - 1 for non-power-of-2 NUM_REQ.

Optional Feature:
- Macro: AES_ARB_KEY_CACHE_EN.
- Defined: key reload rule as above, so the key is strobed only on change.
- Undefined: reload is forced to 1 on every block; key_loaded and key_owner logic is removed.

Decomposition:
- Shared header aes.vh:
  - `BLK_S, `KEY_S.
  - New constants ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_RESP (2-bit encodings).
- One sub-module, aes_rr_pick:
  - Combinational rotate-priority encoder.
  - Inputs: req vector, rr_ptr. Outputs: one-hot grant, grant index, any.

Test Plan:
- FIPS-197 single block: req0, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Expect req_ready[0] once, aes_key_strobe = 1 with aes_en.
  - Expect resp_valid[0] with resp_data 69c4e0d86a7b0430d8cdb78070b4c55a.
- Contention: req0 and req1 valid in the same cycle with rr_ptr = 0.
  - Expect grant order 0, 1, 0, 1 over 4 blocks.
  - resp_valid is one-hot each time and matches the grant.
- Key cache: req0 sends two consecutive blocks, same key, req_key_new = 0.
  - Expect aes_key_strobe only on the first aes_en (with AES_ARB_KEY_CACHE_EN).
  - Expect it on both when the macro is undefined.
- Owner change and force: req1 follows req0 with an identical key → strobe = 1; then req1 with req_key_new = 1 → strobe = 1.
- Backpressure: hold resp_ready[0] = 0 for 10 cycles after resp_valid.
  - resp_data and resp_valid stay stable; busy = 1; no new req_ready.
  - IDLE resumes the cycle after the handshake.
- Reset in WAIT: drop aresetn for 2 cycles before aes_done.
  - All outputs go to 0 immediately; no resp_valid afterwards.
  - Next block re-strobes the key (key_loaded cleared).
